pixel_window_feeder: RTL and testbench

//  Transmit side of the 5x14 pixel-window interface: accepts a raster pixel stream (1 px/cycle,

---
 rtl/pixel_window_feeder.sv | 174 +++++++++++++++++
 tb/tb_pixel_window_feeder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_feeder.sv
// pixel_window_feeder
// Accepts a raster pixel stream into a circular line buffer and presents
// overlapping 5x14 pixel windows, band by band, over a valid/ready handshake.
module pixel_window_feeder #(
  parameter int IMG_W    = 638,
  parameter int IMG_H    = 482,
  parameter int ROW_STEP = 3,
  parameter int COL_STEP = 12,
  parameter int BUF_ROWS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_pixel,
  input  logic         win_ready,
  output logic         win_valid,
  output logic [559:0] pixel_in,
  output logic [7:0]   band_idx,
  output logic [5:0]   win_idx,
  output logic         frame_done
);

  localparam int WIN_ROWS = 5;
  localparam int WIN_COLS = 14;
  localparam int NUM_BAND = (IMG_H - WIN_ROWS) / ROW_STEP + 1;
  localparam int NUM_WIN  = (IMG_W - WIN_COLS) / COL_STEP + 1;
  localparam int RW       = $clog2(IMG_H + BUF_ROWS + 1);
  localparam int CW       = $clog2(IMG_W);
  localparam int SW       = (BUF_ROWS > 1) ? $clog2(BUF_ROWS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]    r_state;
  logic [RW-1:0] r_wrRow;
  logic [CW-1:0] r_wrCol;
  logic [7:0]    r_band;
  logic [5:0]    r_win;
  logic [559:0]  r_pixel;
  logic [7:0]    r_bandIdx;
  logic [5:0]    r_winIdx;
  logic          r_frameDone;
  logic [7:0]    r_mem [BUF_ROWS][IMG_W];

  logic [RW-1:0] w_bandRow;
  logic          w_rowsReady;
  logic          w_inReady;
  logic          w_accept;
  logic          w_take;
  logic          w_lastWin;
  logic          w_lastBand;
  logic [5:0]    w_loadWin;
  logic          w_load;
  logic [559:0]  w_window;

  // First image row of the current band, and the flow-control decisions derived from it.
  // Writes may run at most BUF_ROWS rows ahead of the band being read, so the
  // rows of an unfinished band are never overwritten.
  assign w_bandRow   = RW'(r_band) * RW'(ROW_STEP);
  assign w_rowsReady = r_wrRow >= (w_bandRow + RW'(WIN_ROWS));
  assign w_inReady   = (r_state != S_IDLE) && (r_wrRow < RW'(IMG_H)) &&
                       (r_wrRow < (w_bandRow + RW'(BUF_ROWS)));
  assign w_accept    = in_valid && w_inReady;
  assign w_take      = (r_state == S_EMIT) && win_ready;
  assign w_lastWin   = (r_win == 6'(NUM_WIN - 1));
  assign w_lastBand  = (r_band == 8'(NUM_BAND - 1));
  assign w_loadWin   = (r_state == S_EMIT) ? r_win + 6'd1 : 6'd0;
  assign w_load      = ((r_state == S_FILL) && w_rowsReady) || (w_take && !w_lastWin);

  // Gather the next window from the line buffer: row k of the band, column 12w+j.
  always_comb begin
    w_window = '0;
    for (int k = 0; k < WIN_ROWS; k++) begin
      for (int j = 0; j < WIN_COLS; j++) begin
        w_window[559 - 8*(WIN_COLS*k + j) -: 8] =
          r_mem[SW'((int'(w_bandRow) + k) % BUF_ROWS)][CW'(int'(w_loadWin) * COL_STEP + j)];
      end
    end
  end

  // Line buffer storage; contents need no reset because every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[SW'(int'(r_wrRow) % BUF_ROWS)][r_wrCol] <= in_pixel;
    end
  end

  // Raster write position: cleared on frame start, advanced on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrRow <= '0;
      r_wrCol <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_wrRow <= '0;
        r_wrCol <= '0;
      end
    end else if (w_accept) begin
      if (r_wrCol == CW'(IMG_W - 1)) begin
        r_wrCol <= '0;
        r_wrRow <= r_wrRow + RW'(1);
      end else begin
        r_wrCol <= r_wrCol + CW'(1);
      end
    end
  end

  // Frame sequencing: wait for a band's rows, emit its windows, then advance or finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_band      <= '0;
      r_win       <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_band  <= '0;
            r_win   <= '0;
          end
        end
        S_FILL: begin
          if (w_rowsReady) begin
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_take) begin
            if (!w_lastWin) begin
              r_win <= r_win + 6'd1;
            end else begin
              r_win <= '0;
              if (w_lastBand) begin
                r_state     <= S_IDLE;
                r_frameDone <= 1'b1;
              end else begin
                r_band  <= r_band + 8'd1;
                r_state <= S_FILL;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Window output registers change only when a new window is presented, so they hold during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel   <= '0;
      r_bandIdx <= '0;
      r_winIdx  <= '0;
    end else if (w_load) begin
      r_pixel   <= w_window;
      r_bandIdx <= r_band;
      r_winIdx  <= w_loadWin;
    end
  end

  assign in_ready   = w_inReady;
  assign win_valid  = (r_state == S_EMIT);
  assign pixel_in   = r_pixel;
  assign band_idx   = r_bandIdx;
  assign win_idx    = r_winIdx;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_pixel_window_feeder.sv
// tb_pixel_window_feeder
// Drives raster frames with random handshake gaps into a reduced-size feeder and
// compares every presented window against windows cut directly from the source image.
module tb_pixel_window_feeder;

  localparam int IMG_W    = 50;
  localparam int IMG_H    = 26;
  localparam int ROW_STEP = 3;
  localparam int COL_STEP = 12;
  localparam int BUF_ROWS = 8;
  localparam int NB       = (IMG_H - 5) / ROW_STEP + 1;
  localparam int NW       = (IMG_W - 14) / COL_STEP + 1;
  localparam int TOTAL    = IMG_W * IMG_H;
  localparam int BUDGET   = 20000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_pixel = 8'h00;
  logic         win_ready = 1'b0;
  logic         in_ready;
  logic         win_valid;
  logic [559:0] pixel_in;
  logic [7:0]   band_idx;
  logic [5:0]   win_idx;
  logic         frame_done;

  pixel_window_feeder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ROW_STEP(ROW_STEP), .COL_STEP(COL_STEP), .BUF_ROWS(BUF_ROWS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .win_ready(win_ready), .win_valid(win_valid), .pixel_in(pixel_in),
    .band_idx(band_idx), .win_idx(win_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         b;
    int         w;
    int         k;
    int         j;
    logic [7:0] expByte;
  } probe_t;

  logic [7:0]   img [IMG_H][IMG_W];
  logic [559:0] capt [NB][NW];
  probe_t       probes [8];

  int nChecks = 0;
  int nPass = 0;
  int srcIdx, expB, expW, takes, doneCount, cyc;
  int acceptCyc, firstValidCyc, runLen, runs, badRuns;
  bit prevStall, prevLastTake;
  logic [559:0] prevPix;
  logic [7:0]   prevB;
  logic [5:0]   prevW;

  task automatic checkOutput(input string name, input logic [559:0] got, input logic [559:0] expv);
    nChecks++;
    if (got === expv) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
  endtask

  function automatic logic [559:0] modelWindow(input int b, input int w);
    logic [559:0] v;
    v = '0;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 14; j++)
        v[559 - 8*(14*k + j) -: 8] = img[ROW_STEP*b + k][COL_STEP*w + j];
    return v;
  endfunction

  task automatic fillImage(input bit ramp);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = ramp ? 8'((r + c) & 255) : 8'($urandom_range(0, 255));
  endtask

  task automatic takeWindow();
    if (expB >= NB) begin
      nChecks++;
      $display("[TB] FAIL extra window: got b=%0d w=%0d expected none", band_idx, win_idx);
    end else begin
      checkOutput("band_idx", band_idx, expB);
      checkOutput("win_idx", win_idx, expW);
      checkOutput("pixel_in", pixel_in, modelWindow(expB, expW));
      capt[expB][expW] = pixel_in;
      takes++;
      expW++;
      if (expW == NW) begin
        expW = 0;
        expB++;
      end
    end
  endtask

  // One cycle: drive inputs at the falling edge, then observe the state left by the last rising edge.
  task automatic applyStimulus(input int inGap, input int outGap, input bit st);
    bit take;
    @(negedge clk);
    start     = st;
    in_valid  = (srcIdx < TOTAL) && (inGap == 0 || $urandom_range(0, 99) >= inGap);
    in_pixel  = (srcIdx < TOTAL) ? img[srcIdx / IMG_W][srcIdx % IMG_W] : 8'h00;
    win_ready = (outGap == 0) || ($urandom_range(0, 99) >= outGap);
    #1;
    cyc++;
    if (prevStall) begin
      checkOutput("held pixel_in", pixel_in, prevPix);
      checkOutput("held valid/idx", {win_valid, band_idx, win_idx}, {1'b1, prevB, prevW});
    end
    if (prevLastTake) checkOutput("valid gap after band", win_valid, 1'b0);
    if (win_valid) runLen++;
    else if (runLen > 0) begin
      runs++;
      if (runLen != NW) badRuns++;
      runLen = 0;
    end
    if (win_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (frame_done) doneCount++;
    take         = win_valid && win_ready;
    prevStall    = win_valid && !win_ready;
    prevPix      = pixel_in;
    prevB        = band_idx;
    prevW        = win_idx;
    prevLastTake = take && (expW == NW - 1) && (expB < NB);
    if (in_valid && in_ready) begin
      srcIdx++;
      if (srcIdx == 5 * IMG_W) acceptCyc = cyc;
    end
    if (take) takeWindow();
  endtask

  task automatic startFrame(input int hold, input int inGap);
    srcIdx = 0; expB = 0; expW = 0; takes = 0; doneCount = 0; cyc = 0;
    acceptCyc = -1; firstValidCyc = -1; runLen = 0; runs = 0; badRuns = 0;
    prevStall = 1'b0; prevLastTake = 1'b0;
    repeat (hold) applyStimulus(inGap, 0, 1'b1);
  endtask

  task automatic finishFrame(input int inGap, input int outGap, input bit randStart);
    int n;
    n = 0;
    while (expB < NB && n < BUDGET) begin
      applyStimulus(inGap, outGap, randStart && ($urandom_range(0, 9) == 0));
      n++;
    end
    checkOutput("frame within budget", n < BUDGET, 1'b1);
    repeat (3) applyStimulus(0, 0, 1'b0);
    checkOutput("windows taken", takes, NB * NW);
    checkOutput("frame_done pulses", doneCount, 1);
    checkOutput("idle after frame", {in_ready, win_valid}, 2'b00);
    checkOutput("first window latency", firstValidCyc - acceptCyc, 2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int t0;
    logic [559:0] v;

    // Ramp probes: px(r,c) = r+c, so byte (k,j) of window (b,w) is 3b+k+12w+j.
    probes[0] = '{0, 0, 0, 0,  8'h00};
    probes[1] = '{0, 0, 1, 0,  8'h01};
    probes[2] = '{0, 0, 4, 13, 8'h11};
    probes[3] = '{0, 3, 0, 0,  8'h24};
    probes[4] = '{2, 1, 2, 5,  8'h19};
    probes[5] = '{5, 2, 3, 7,  8'h31};
    probes[6] = '{7, 3, 0, 0,  8'h39};
    probes[7] = '{7, 3, 4, 13, 8'h4A};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset ready/valid/done", {in_ready, win_valid, frame_done}, 3'b000);
    checkOutput("reset pixel_in", pixel_in, '0);
    checkOutput("reset idx", {band_idx, win_idx}, 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    srcIdx = 0;
    applyStimulus(0, 0, 1'b0);
    checkOutput("in_ready idle before start", in_ready, 1'b0);

    $display("[TB] ramp frame, continuous handshakes");
    fillImage(1'b1);
    startFrame(1, 0);
    finishFrame(0, 0, 1'b0);
    checkOutput("band runs", runs, NB);
    checkOutput("runs not back-to-back", badRuns, 0);
    for (int i = 0; i < 8; i++) begin
      v = capt[probes[i].b][probes[i].w];
      checkOutput($sformatf("probe b%0d w%0d k%0d j%0d", probes[i].b, probes[i].w, probes[i].k, probes[i].j),
                  v[559 - 8*(14*probes[i].k + probes[i].j) -: 8], probes[i].expByte);
    end

    $display("[TB] consumer stalled from start");
    startFrame(1, 0);
    repeat (BUF_ROWS * IMG_W + 40) applyStimulus(0, 100, 1'b0);
    checkOutput("pixels accepted before stall", srcIdx, BUF_ROWS * IMG_W);
    checkOutput("in_ready stalled", in_ready, 1'b0);
    checkOutput("window waiting", win_valid, 1'b1);
    checkOutput("frozen window", pixel_in, modelWindow(0, 0));
    t0 = takes;
    n = 0;
    do begin
      applyStimulus(0, 0, 1'b0);
      n++;
    end while (!in_ready && n < 100);
    checkOutput("in_ready returns", in_ready, 1'b1);
    checkOutput("windows before resume", takes - t0, NW);
    finishFrame(0, 0, 1'b0);

    $display("[TB] ramp frame, random gaps");
    startFrame(1, 30);
    finishFrame(30, 30, 1'b0);

    $display("[TB] reset mid-frame");
    fillImage(1'b0);
    startFrame(1, 0);
    n = 0;
    while (!(expB == 4 && expW == 2) && n < BUDGET) begin
      applyStimulus(10, 10, 1'b0);
      n++;
    end
    checkOutput("reached band 4", n < BUDGET, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort ready/valid/done", {in_ready, win_valid, frame_done}, 3'b000);
    checkOutput("abort pixel_in", pixel_in, '0);
    checkOutput("abort idx", {band_idx, win_idx}, 14'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    startFrame(1, 0);
    finishFrame(25, 25, 1'b0);

    $display("[TB] start pulses mid-frame, then start held in idle");
    fillImage(1'b0);
    startFrame(1, 0);
    finishFrame(15, 15, 1'b1);
    srcIdx = 0;
    prevStall = 1'b0;
    prevLastTake = 1'b0;
    repeat (3) applyStimulus(0, 0, 1'b0);
    checkOutput("no accept in idle", srcIdx, 0);
    startFrame(3, 0);
    finishFrame(0, 0, 1'b0);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
